// File: rtl/reg_file_pkg.sv
// Shared constants and debug-sequencer state encoding for the decode-stage register file.
package reg_file_pkg;

  localparam int unsigned RF_WIDTH_B = 32;
  localparam int unsigned RF_ADDR_B  = 5;

  typedef enum logic {
    StIdle = 1'b0,
    StDump = 1'b1
  } dbg_state_e;

endpackage

// File: rtl/reg_file_dbg_seq.sv
// Debug dump sequencer: walks every register index and presents one snapshot beat
// per cycle on a valid/ready port.
module reg_file_dbg_seq
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH_B = RF_WIDTH_B,
  parameter int unsigned ADDR_B  = RF_ADDR_B
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_ready,
  input  logic [WIDTH_B-1:0] i_snap_data,
  output logic [ADDR_B-1:0]  o_snap_addr,
  output logic               o_valid,
  output logic [ADDR_B-1:0]  o_addr,
  output logic [WIDTH_B-1:0] o_data,
  output logic               o_last,
  output logic               o_busy
);

  localparam logic [ADDR_B-1:0] IdxMax = '1;

  dbg_state_e         r_state, w_state_nxt;
  logic [ADDR_B-1:0]  r_idx, w_idx_nxt;
  logic               r_valid, w_valid_nxt;
  logic [WIDTH_B-1:0] r_data, w_data_nxt;

  // o_snap_addr names the register captured at the coming edge, if a capture happens.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_valid_nxt = r_valid;
    w_data_nxt  = r_data;
    o_snap_addr = r_idx + 1'b1;
    unique case (r_state)
      StIdle: begin
        o_snap_addr = '0;
        if (i_start) begin
          w_idx_nxt   = '0;
          w_data_nxt  = i_snap_data;
          w_valid_nxt = 1'b1;
          w_state_nxt = StDump;
        end
      end
      StDump: begin
        if (i_ready) begin
          if (r_idx != IdxMax) begin
            w_idx_nxt  = r_idx + 1'b1;
            w_data_nxt = i_snap_data;
          end else begin
            w_valid_nxt = 1'b0;
            w_state_nxt = StIdle;
          end
        end
      end
      default: begin
        w_valid_nxt = 1'b0;
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_valid <= w_valid_nxt;
      r_data  <= w_data_nxt;
    end
  end

  assign o_valid = r_valid;
  assign o_addr  = r_idx;
  assign o_data  = r_data;
  assign o_last  = r_valid && (r_idx == IdxMax);
  assign o_busy  = (r_state == StDump);

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with optional zero register, write bypass and a
// debug dump port that never stalls the normal read/write traffic.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH_B  = RF_WIDTH_B,
  parameter int unsigned ADDR_B   = RF_ADDR_B,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      RegWrite,
  input  logic [ADDR_B-1:0]         Write_Addr,
  input  logic [WIDTH_B-1:0]        Write_Data,
  input  logic [NUM_RD*ADDR_B-1:0]  Read_Addr,
  output logic [NUM_RD*WIDTH_B-1:0] Read_Data,
  input  logic                      dbg_start,
  input  logic                      dbg_ready,
  output logic                      dbg_valid,
  output logic [ADDR_B-1:0]         dbg_addr,
  output logic [WIDTH_B-1:0]        dbg_data,
  output logic                      dbg_last,
  output logic                      dbg_busy
);

  localparam int unsigned DEPTH = 1 << ADDR_B;

  logic [WIDTH_B-1:0] r_mem [DEPTH];
  logic               w_wr_en;
  logic [WIDTH_B-1:0] w_rd_data [NUM_RD];
  logic [ADDR_B-1:0]  w_snap_addr;
  logic [WIDTH_B-1:0] w_snap_data;

  assign w_wr_en = RegWrite && !((ZERO_REG != 0) && (Write_Addr == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[Write_Addr] <= Write_Data;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_B-1:0] w_addr;
    assign w_addr = Read_Addr[g*ADDR_B +: ADDR_B];
    assign w_rd_data[g] =
        ((ZERO_REG != 0) && (w_addr == '0))                 ? '0 :
        ((BYPASS != 0) && RegWrite && (w_addr == Write_Addr)) ? Write_Data :
                                                                r_mem[w_addr];
    assign Read_Data[g*WIDTH_B +: WIDTH_B] = w_rd_data[g];
  end

  // Dump snapshots always forward same-cycle writes, whatever BYPASS is set to.
  assign w_snap_data =
      ((ZERO_REG != 0) && (w_snap_addr == '0))  ? '0 :
      (RegWrite && (w_snap_addr == Write_Addr)) ? Write_Data :
                                                  r_mem[w_snap_addr];

  reg_file_dbg_seq #(
    .WIDTH_B (WIDTH_B),
    .ADDR_B  (ADDR_B)
  ) u_dbg_seq (
    .i_clk       (clk),
    .i_rst       (reset),
    .i_start     (dbg_start),
    .i_ready     (dbg_ready),
    .i_snap_data (w_snap_data),
    .o_snap_addr (w_snap_addr),
    .o_valid     (dbg_valid),
    .o_addr      (dbg_addr),
    .o_data      (dbg_data),
    .o_last      (dbg_last),
    .o_busy      (dbg_busy)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: vector table for read/write/bypass, scoreboard for dump beats.
module tb_reg_file_mp;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        RegWrite = 1'b0;
  logic [4:0]  Write_Addr = '0;
  logic [31:0] Write_Data = '0;
  logic [9:0]  Read_Addr = '0;
  logic [63:0] Read_Data;
  logic        dbg_start = 1'b0;
  logic        dbg_ready = 1'b0;
  logic        dbg_valid;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        dbg_last;
  logic        dbg_busy;

  logic [63:0] nb_read_data;
  logic        nb_valid;
  logic [4:0]  nb_addr;
  logic [31:0] nb_data;
  logic        nb_last;
  logic        nb_busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] model [DEPTH];
  logic [38:0] sb [$];

  always #5 clk = ~clk;

  reg_file_mp dut (
    .clk        (clk),
    .reset      (reset),
    .RegWrite   (RegWrite),
    .Write_Addr (Write_Addr),
    .Write_Data (Write_Data),
    .Read_Addr  (Read_Addr),
    .Read_Data  (Read_Data),
    .dbg_start  (dbg_start),
    .dbg_ready  (dbg_ready),
    .dbg_valid  (dbg_valid),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .dbg_last   (dbg_last),
    .dbg_busy   (dbg_busy)
  );

  reg_file_mp #(.BYPASS(0)) dut_nb (
    .clk        (clk),
    .reset      (reset),
    .RegWrite   (RegWrite),
    .Write_Addr (Write_Addr),
    .Write_Data (Write_Data),
    .Read_Addr  (Read_Addr),
    .Read_Data  (nb_read_data),
    .dbg_start  (1'b0),
    .dbg_ready  (1'b0),
    .dbg_valid  (nb_valid),
    .dbg_addr   (nb_addr),
    .dbg_data   (nb_data),
    .dbg_last   (nb_last),
    .dbg_busy   (nb_busy)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] exp0;
    logic [31:0] exp1;
    logic [31:0] nb0;
    logic [31:0] nb1;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic write_reg(input int a, input logic [31:0] d);
    @(negedge clk);
    RegWrite   = 1'b1;
    Write_Addr = 5'(a);
    Write_Data = d;
    if (a != 0) model[a] = d;
  endtask

  // Runs one dump. Optional: stall 3 cycles at stall_at (writing 0xAA there),
  // pulse dbg_start at restart_at, assert reset at reset_at.
  task automatic run_dump(input int stall_at, input int restart_at, input int reset_at);
    int stall_left;
    bit done;
    stall_left = 3;
    done = 1'b0;
    @(negedge clk);
    RegWrite  = 1'b0;
    dbg_start = 1'b1;
    dbg_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      sb.push_back({1'b1, 1'(i == DEPTH - 1), 5'(i), model[i]});
    end
    #1 check("first_beat_latency", 64'(dbg_valid), 64'd0);
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      @(negedge clk);
      dbg_start = 1'b0;
      RegWrite  = 1'b0;
      dbg_ready = 1'b1;
      if (dbg_valid && int'(dbg_addr) == stall_at && stall_left > 0) begin
        dbg_ready = 1'b0;
        if (stall_left == 3) begin
          RegWrite   = 1'b1;
          Write_Addr = 5'(stall_at);
          Write_Data = 32'hAA;
          model[stall_at] = 32'hAA;
        end
        stall_left--;
      end
      if (dbg_valid && int'(dbg_addr) == restart_at) dbg_start = 1'b1;
      if (dbg_valid && int'(dbg_addr) == reset_at) begin
        reset = 1'b1;
        #1 check("reset_abort", {dbg_busy, dbg_last, dbg_valid, dbg_addr, dbg_data}, 64'd0);
        sb.delete();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        done = 1'b1;
      end else begin
        #1;
        if (!dbg_valid) begin
          check("dump_end_busy", 64'(dbg_busy), 64'd0);
          check("dump_beats_missing", 64'(sb.size()), 64'd0);
          done = 1'b1;
        end else if (sb.size() == 0) begin
          check("dump_extra_beat", {dbg_last, dbg_addr, dbg_data}, 64'd0);
          done = 1'b1;
        end else begin
          check($sformatf("beat%0d", sb[0][36:32]),
                {dbg_busy, dbg_last, dbg_addr, dbg_data}, 64'(sb[0]));
          if (dbg_ready) void'(sb.pop_front());
        end
      end
    end
    if (!done) check("dump_timeout", 64'd1, 64'd0);
    dbg_start = 1'b0;
    RegWrite  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,
                 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,
                 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,
                 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,
                 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[4]  = '{1'b1, 5'd7,  32'h11111111, 5'd3,  5'd7,
                 32'h0, 32'h11111111, 32'h0, 32'h0};
    vecs[5]  = '{1'b1, 5'd7,  32'h12345678, 5'd7,  5'd5,
                 32'h12345678, 32'hDEADBEEF, 32'h11111111, 32'hDEADBEEF};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,
                 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
    vecs[7]  = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd30,
                 32'hA5A5A5A5, 32'h0, 32'h0, 32'h0};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        5'd30, 5'd31,
                 32'h0, 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5};
    vecs[9]  = '{1'b1, 5'd5,  32'h0BADF00D, 5'd5,  5'd5,
                 32'h0BADF00D, 32'h0BADF00D, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,
                 32'h0BADF00D, 32'h0BADF00D, 32'h0BADF00D, 32'h0BADF00D};

    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Preload, then clear with reset held and sweep every address.
    for (int i = 1; i < DEPTH; i++) write_reg(i, 32'h100 + 32'(i));
    @(negedge clk);
    RegWrite = 1'b0;
    reset = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      Read_Addr = {5'(DEPTH - 1 - a), 5'(a)};
      #1;
      check($sformatf("reset_rd%0d_p0", a), 64'(Read_Data[31:0]), 64'd0);
      check($sformatf("reset_rd%0d_p1", a), 64'(Read_Data[63:32]), 64'd0);
    end
    check("reset_dbg_valid", 64'(dbg_valid), 64'd0);
    check("reset_dbg_busy", 64'(dbg_busy), 64'd0);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      RegWrite   = vecs[i].we;
      Write_Addr = vecs[i].wa;
      Write_Data = vecs[i].wd;
      Read_Addr  = {vecs[i].ra1, vecs[i].ra0};
      #1;
      check($sformatf("vec%0d_p0", i), 64'(Read_Data[31:0]), 64'(vecs[i].exp0));
      check($sformatf("vec%0d_p1", i), 64'(Read_Data[63:32]), 64'(vecs[i].exp1));
      check($sformatf("vec%0d_nb_p0", i), 64'(nb_read_data[31:0]), 64'(vecs[i].nb0));
      check($sformatf("vec%0d_nb_p1", i), 64'(nb_read_data[63:32]), 64'(vecs[i].nb1));
    end

    // Full dump with ready held high.
    for (int i = 0; i < DEPTH; i++) write_reg(i, 32'(i * 3));
    run_dump(-1, -1, -1);

    // Backpressure at beat 10 with a write to r10 underneath it.
    run_dump(10, -1, -1);
    @(negedge clk);
    Read_Addr = {5'd11, 5'd10};
    #1;
    check("post_stall_r10", 64'(Read_Data[31:0]), 64'(model[10]));
    check("post_stall_r11", 64'(Read_Data[63:32]), 64'(model[11]));

    // Ignored restart at beat 5, reset at beat 15.
    run_dump(-1, 5, 15);
    @(negedge clk);
    reset = 1'b0;
    dbg_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1 check($sformatf("post_reset_idle%0d", c), {dbg_busy, dbg_valid}, 64'd0);
    end
    Read_Addr = {5'd31, 5'd10};
    #1;
    check("post_reset_r10", 64'(Read_Data[31:0]), 64'(model[10]));
    check("post_reset_r31", 64'(Read_Data[63:32]), 64'(model[31]));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
